// File: rtl/control.sv
// Bus/processor request arbiter: a 4-state Moore FSM whose state code is the status output.
// Priority is stop, then write, then read; STOP always exits through IDLE.
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic       BW,
  input  logic       BR,
  input  logic       PW,
  input  logic       PR,
  input  logic       S,
  output logic [1:0] status
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t state;
  state_t state_next;
  logic   w;
  logic   r;

  assign w = BW | PW;
  assign r = BR | PR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE, WRITE, READ: begin
        if (S) begin
          state_next = STOP;
        end else if (w) begin
          state_next = WRITE;
        end else if (r) begin
          state_next = READ;
        end else begin
          state_next = IDLE;
        end
      end
      // Requests are ignored in STOP so the exit always passes through IDLE.
      STOP: state_next = S ? STOP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign status = state;

endmodule

// File: tb/tb_control.sv
// Directed bench for control: a behavioural model checked every negative edge,
// plus literal expectations at the scenario checkpoints.
module tb_control;

  logic       clk;
  logic       rst;
  logic       BW;
  logic       BR;
  logic       PW;
  logic       PR;
  logic       S;
  logic [1:0] status;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_state;

  control dut (
    .clk    (clk),
    .rst    (rst),
    .BW     (BW),
    .BR     (BR),
    .PW     (PW),
    .PR     (PR),
    .S      (S),
    .status (status)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what the state must be, straight from the priority rules.
  function automatic logic [1:0] model_next(input logic [1:0] cur, input logic bw,
                                            input logic br, input logic pw,
                                            input logic pr, input logic s);
    logic want_write;
    logic want_read;
    want_write = bw || pw;
    want_read  = br || pr;
    if (cur == 2'b11) return s ? 2'b11 : 2'b00;
    if (s) return 2'b11;
    if (want_write) return 2'b01;
    if (want_read) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) exp_state <= 2'b00;
    else      exp_state <= model_next(exp_state, BW, BR, PW, PR, S);
  end

  // Compare process: status vs model on every falling edge.
  always @(negedge clk) begin
    checks++;
    if (status !== exp_state) begin
      errors++;
      $display("FAIL model_cmp t=%0t status=%b expected=%b", $time, status, exp_state);
    end
  end

  task automatic check_lit(input string name, input logic [1:0] expv);
    checks++;
    if (status !== expv) begin
      errors++;
      $display("FAIL %s t=%0t status=%b expected=%b", name, $time, status, expv);
    end
  endtask

  // Driver: set inputs just after a falling edge, return just after the next rising edge.
  task automatic step(input logic bw, input logic br, input logic pw,
                      input logic pr, input logic s);
    @(negedge clk);
    #1;
    BW = bw; BR = br; PW = pw; PR = pr; S = s;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;
    BW = 0; BR = 0; PW = 0; PR = 0; S = 0;
    hold(3);
    check_lit("reset_idle", 2'b00);

    // Reset release with BW=1 -> WRITE after the first edge, held 2 cycles.
    @(negedge clk);
    #1;
    rst = 1'b1;
    BW  = 1'b1;
    @(posedge clk);
    #1;
    check_lit("reset_exit_write", 2'b01);
    hold(1);
    check_lit("write_hold", 2'b01);

    // Request sequence.
    step(0, 0, 1, 0, 0);
    check_lit("pw_write", 2'b01);
    step(0, 1, 0, 0, 0);
    check_lit("br_read", 2'b10);
    step(0, 0, 0, 0, 0);
    check_lit("all_zero_idle", 2'b00);
    step(0, 0, 0, 1, 0);
    check_lit("pr_read", 2'b10);

    // Priority: write beats read, stop beats everything.
    step(1, 0, 0, 1, 0);
    check_lit("write_over_read", 2'b01);
    step(0, 0, 0, 1, 1);
    check_lit("stop_enter", 2'b11);
    for (int i = 0; i < 9; i++) step(i[0], i[1], i[2], 1, 1);
    check_lit("stop_held_10", 2'b11);

    // Stop exit passes through IDLE even with a write pending.
    step(1, 0, 0, 0, 0);
    check_lit("stop_exit_idle", 2'b00);
    hold(1);
    check_lit("stop_exit_write", 2'b01);

    // Async reset from READ, between edges.
    step(0, 1, 0, 0, 0);
    check_lit("pre_reset_read", 2'b10);
    #2;
    rst = 1'b0;
    #1;
    check_lit("async_reset_now", 2'b00);
    PR = 1'b1;
    hold(3);
    check_lit("reset_ignores_pr", 2'b00);

    // Async reset from STOP.
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 1);
    check_lit("stop_again", 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check_lit("async_reset_stop", 2'b00);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    hold(1);

    // Glitch: BR pulse strictly between rising edges is never sampled.
    @(posedge clk);
    #3;
    BR = 1'b1;
    #2;
    BR = 1'b0;
    @(posedge clk);
    #1;
    check_lit("glitch_idle", 2'b00);

    // Same-cycle stop vs write from WRITE.
    step(1, 0, 0, 0, 0);
    check_lit("write_again", 2'b01);
    step(1, 1, 1, 1, 1);
    check_lit("stop_overrides_all", 2'b11);
    step(0, 0, 0, 0, 0);
    check_lit("idle_final", 2'b00);
    hold(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
